project2_moore_fsm: RTL and testbench
=====================================

# project2_moore_fsm

Four-state Moore finite-state machine that tracks how many consecutive `1`s have been seen on a serial input `x`. It saturates at three. The outputs `y2`/`y1` are a pure function of the registered state and carry its 2-bit code. The block is a stand-alone leaf used by the project-2 sequential-logic exercise; its outputs are consumed directly as status bits.

## Interface
- No parameters; state width is fixed at 2 bits.
- `clk`  input  1  system clock; all state updates occur on the rising edge.
- `rst_n`  input  1  reset; one clock; reset is asynchronous and active-low.
- `x`  input  1  serial data bit; sampled on each rising `clk` edge.
- `y2`  output  1  MSB of the current state code.
- `y1`  output  1  LSB of the current state code.

## Operation
- States and codes `{y2,y1}`:
  - S0 = 00: no trailing `1`.
  - S1 = 01: one trailing `1`.
  - S2 = 10: two trailing `1`s.
  - S3 = 11: three or more trailing `1`s.
- Transitions are evaluated at each rising `clk` edge using the sampled `x`:
  - x=1: S0→S1, S1→S2, S2→S3, S3→S3 (saturates).
  - x=0: any state → S0.
- Moore outputs:
  - `{y2,y1}` = state code.
  - Outputs are never combinationally dependent on `x`.
  - Outputs come straight from the state flip-flops, so they are glitch-free.
- No illegal states exist; all four 2-bit codes are defined. A simulation X on `x` leaves the state undefined, so the bench must drive `x` from time 0 or hold `rst_n` low.

## Timing
- Reset:
  - `rst_n`=0 forces the state to S0 immediately, without waiting for a clock edge; outputs become `y2`=0, `y1`=0.
  - The state holds S0 while `rst_n` is low, regardless of `clk` or `x`.
- Reset release: the first rising `clk` edge with `rst_n`=1 performs a normal transition from S0.
- Reset asserted mid-run: the state returns to S0 asynchronously; the run-length history is lost.
- Latency: one cycle. A value of `x` sampled at edge k is reflected on `y2`/`y1` right after edge k and stays stable until edge k+1.
- Throughput: one input bit per clock, with no handshake.
- `x` must meet setup/hold time around the rising edge. In simulation, stimulus changing in the same timestep as `posedge clk` is ambiguous; benches must change `x` on the falling edge.

## Structure
- Shared package `project2_pkg`:
  - 2-bit state typedef `state_t`.
  - Constants `S0`=2'b00, `S1`=2'b01, `S2`=2'b10, `S3`=2'b11.
- RTL organisation:
  - One state register block: asynchronous active-low reset.
  - One combinational next-state block: case on state, with a default of S0.
  - Continuous output assignments from the state.
- No sub-module is needed.
- Optional simulation-only assertion: outputs equal the state code, and are 00 whenever `rst_n` is low.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `x` toggling → `{y2,y1}`=00 throughout; deassert `rst_n` on a falling edge → still 00 until the next rising edge.
- Run of ones: after reset, drive x=1,1,1,1,1 → outputs after each edge 01,10,11,11,11.
- Break in run: drive x=1,1,0,1 → 01,10,00,01.
- Zeros only: drive x=0,0,0,0 from S0 → 00 every cycle.
- Mixed stream: drive x=1,0,0,0,0,1,1,1,0,1,1,0,0,1,1,1,1,0,1,1 → 01,00,00,00,00,01,10,11,00,01,10,00,00,01,10,11,11,00,01,10.
- Asynchronous reset mid-run: in S3, pulse `rst_n` low for 3 ns between clock edges → outputs go to 00 within the pulse, with no clock edge required; next edge with x=1 → 01.

Source files
------------

// File: rtl/project2_pkg.sv
// project2_pkg: state type and codes for the consecutive-ones Moore FSM
package project2_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S0 = 2'b00;
  localparam state_t S1 = 2'b01;
  localparam state_t S2 = 2'b10;
  localparam state_t S3 = 2'b11;
endpackage

// File: rtl/project2_moore_fsm.sv
// project2_moore_fsm: saturating count of trailing ones on x, state code driven on {y2,y1}
module project2_moore_fsm
  import project2_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  output logic y2,
  output logic y1
);
  state_t state, state_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S0;
    else state <= state_next;
  always_comb begin
    state_next = S0;
    case (state)
      S0: state_next = x ? S1 : S0;
      S1: state_next = x ? S2 : S0;
      S2: state_next = x ? S3 : S0;
      S3: state_next = x ? S3 : S0;
      default: state_next = S0;
    endcase
  end
  always_comb begin
    y2 = state[1];
    y1 = state[0];
  end
endmodule

// File: tb/tb_project2_moore_fsm.sv
// tb_project2_moore_fsm: random and directed serial streams checked through a scoreboard queue
module tb_project2_moore_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x = 1'b0;
  logic y2, y1;
  int compared = 0;
  int mismatched = 0;
  int run = 0;
  logic [1:0] exp_q[$];

  project2_moore_fsm dut (.clk(clk), .rst_n(rst_n), .x(x), .y2(y2), .y1(y1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: number of trailing ones seen since reset, capped at three
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) run = 0;
    else begin
      run = x ? (run < 3 ? run + 1 : 3) : 0;
      exp_q.push_back(run[1:0]);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && exp_q.size() > 0) check("stream", {y2, y1}, exp_q.pop_front());
  end

  task automatic drive(input logic b);
    @(negedge clk);
    x = b;
  endtask

  task automatic async_pulse(input string name);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check(name, {y2, y1}, 2'b00);
    #2 rst_n = 1'b1;
  endtask

  logic [19:0] mixed;
  logic [4:0] brk;

  initial begin
    repeat (2) begin
      @(negedge clk);
      x = ~x;
      @(posedge clk);
      #1 check("reset_hold", {y2, y1}, 2'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    x = 1'b1;
    #1 check("reset_release", {y2, y1}, 2'b00);
    repeat (4) drive(1'b1);
    brk = 5'b10110;
    for (int i = 4; i >= 0; i--) drive(brk[i]);
    repeat (4) drive(1'b0);
    mixed = 20'b1000_0111_0110_0111_1011;
    for (int i = 19; i >= 0; i--) drive(mixed[i]);
    repeat (4) drive(1'b1);
    async_pulse("async_reset_s3");
    x = 1'b1;
    drive(1'b1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) async_pulse("async_reset_rand");
      drive($urandom_range(0, 3) != 0);
    end
    drive(1'b0);
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
